program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Write-side counterpart to the fetch path: streams a program into program RAM before the core runs.
//  - Accepts bytes over a valid/ready handshake.
//  - Packs byte pairs big-endian into 16-bit instruction words.
//  - Writes the words to consecutive program RAM addresses from 0.
//  - Sits in front of memory_controller/ram_single_port_sync and owns the RAM port while busy.
//  - Asserts done to release the execution driver.
// PARAMETERS
//  ADDRESS_WIDTH  16  width of ram_address and length
//  DATA_WIDTH     16  RAM word width; must equal 2*BYTE
//  BYTE           8   width of byte_in
//  MEMORY_DEPTH   64  words of program RAM; upper bound on length
// PORTS
//  clock        in   1              system clock, rising edge
//  reset        in   1              asynchronous, active-high
//  start        in   1              1-cycle pulse: begin a load; sampled only in IDLE
//  length       in   ADDRESS_WIDTH  number of words to load; sampled with start
//  byte_in      in   BYTE           incoming program byte
//  byte_valid   in   1              byte_in is valid
//  byte_ready   out  1              loader can accept byte_in this cycle
//  ram_rw       out  1              1 = write strobe to program RAM
//  ram_address  out  ADDRESS_WIDTH  RAM word address
//  ram_data     out  DATA_WIDTH     RAM write data
//  busy         out  1              load in progress (RECV_HI..WRITE, CHECK)
//  done         out  1              load completed successfully; held
//  error        out  1              load rejected or failed; held
// BEHAVIOUR
//  - Reset (async): state=IDLE. All outputs 0. Word pointer and byte register cleared.
//  - Reset mid-load: abandons the load. RAM words already written stay written.
//  - FSM states: IDLE, RECV_HI, RECV_LO, WRITE, CHECK (optional), DONE, ERROR.
//  - IDLE, on start:
//      - length==0: go to DONE.
//      - length>MEMORY_DEPTH: go to ERROR.
//      - otherwise: latch length, ptr=0, go to RECV_HI.
//  - A byte transfer occurs only when byte_valid && byte_ready on a clock edge.
//  - byte_ready is a registered output: 1 exactly in RECV_HI, RECV_LO and CHECK.
//  - byte_ready never depends combinationally on byte_valid.
//  - RECV_HI, on transfer: hi=byte_in, go to RECV_LO.
//  - RECV_LO, on transfer: register ram_data={hi,byte_in}, ram_address=ptr, go to WRITE.
//  - WRITE lasts exactly 1 cycle with ram_rw=1. byte_ready=0.
//  - Leaving WRITE:
//      - ptr==length-1: go to CHECK (macro defined) or DONE.
//      - else: ptr=ptr+1, go to RECV_HI.
//  - ram_rw is 0 in every state except WRITE. ram_address/ram_data hold their last values outside WRITE.
//  - Throughput: max 1 word per 3 cycles. Latency from low-byte transfer to write strobe is 1 cycle.
//  - DONE / ERROR: busy=0, flag held. A new start clears the flag and re-runs the IDLE checks.
//  - start while busy is ignored. length changes while busy are ignored.
//  - Address arithmetic is unsigned ADDRESS_WIDTH. ptr never exceeds MEMORY_DEPTH-1, so no wrap-around.
//  - done and error are never 1 together.
// CONFIGURATION
//  PROGRAM_LOADER_CHECKSUM_EN defined:
//  - After the last write, go to CHECK and accept one extra checksum byte.
//  - An 8-bit running sum covers all data bytes plus the checksum byte.
//  - Sum mod 256 == 0 -> DONE. Otherwise -> ERROR.
//  - The running sum is cleared on start.
//  PROGRAM_LOADER_CHECKSUM_EN undefined:
//  - No CHECK state and no sum register.
//  - Last WRITE goes directly to DONE.
// TESTING
//  - Reset: assert reset mid-RECV_LO -> same cycle: byte_ready=0, ram_rw=0, busy=0, done=0. State IDLE after release.
//  - Basic load: length=2, bytes 01,02,03,04 with valid held high ->
//      - ram_rw pulses twice: addr0=0x0102, addr1=0x0304.
//      - done=1; RAM readback matches.
//  - Backpressure: drop byte_valid for 5 cycles between hi and lo -> no write until lo arrives. Data still 0x0102.
//  - Bounds:
//      - length=0 -> done=1 next cycle, no ram_rw.
//      - length=65 (MEMORY_DEPTH=64) -> error=1, no ram_rw.
//  - Full depth: length=64 -> last write at address 63, done=1, ptr does not wrap.
//  - Checksum (macro on): bytes 01,02 then checksum FD -> done=1. Checksum FE -> error=1, word 0x0102 still written.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: streams bytes over valid/ready into program RAM as big-endian 16-bit words
// Ports: clock/reset (async, active-high); start+length begin a load; byte_in/byte_valid/byte_ready
// byte handshake; ram_rw/ram_address/ram_data drive the RAM write port; busy/done/error report status.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum byte whose
// 8-bit sum with all data bytes must be zero.
module program_loader #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BYTE = 8,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic [ADDRESS_WIDTH-1:0] length,
  input  logic [BYTE-1:0] byte_in,
  input  logic byte_valid,
  output logic byte_ready,
  output logic ram_rw,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic busy,
  output logic done,
  output logic error
);
  localparam logic [2:0] IDLE = 3'd0, RECV_HI = 3'd1, RECV_LO = 3'd2, WRITE = 3'd3, DONE = 3'd5, ERROR = 3'd6;
  logic [2:0] state, nxt;
  logic [ADDRESS_WIDTH-1:0] len, ptr;
  logic [BYTE-1:0] hi;
  logic xfer, last, load, ready_nxt, busy_nxt;
  logic [2:0] launch, after_last;
  assign xfer = byte_valid && byte_ready;
  assign last = ptr == len - ADDRESS_WIDTH'(1);
  assign load = start && (state == IDLE || state == DONE || state == ERROR);
  assign launch = length == '0 ? DONE : length > ADDRESS_WIDTH'(MEMORY_DEPTH) ? ERROR : RECV_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd4;
  logic [BYTE-1:0] sum;
  logic check_ok;
  assign check_ok = BYTE'(sum + byte_in) == '0;
  assign after_last = CHECK;
  assign ready_nxt = nxt == RECV_HI || nxt == RECV_LO || nxt == CHECK;
  assign busy_nxt = ready_nxt || nxt == WRITE;
`else
  assign after_last = DONE;
  assign ready_nxt = nxt == RECV_HI || nxt == RECV_LO;
  assign busy_nxt = ready_nxt || nxt == WRITE;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: nxt = start ? launch : state;
      RECV_HI: nxt = xfer ? RECV_LO : state;
      RECV_LO: nxt = xfer ? WRITE : state;
      WRITE: nxt = last ? after_last : RECV_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: nxt = xfer ? (check_ok ? DONE : ERROR) : state;
`endif
      default: nxt = IDLE;
    endcase
  end
  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      byte_ready <= 1'b0;
      ram_rw <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      len <= '0;
      ptr <= '0;
      hi <= '0;
      ram_address <= '0;
      ram_data <= '0;
    end else begin
      state <= nxt;
      byte_ready <= ready_nxt;
      ram_rw <= nxt == WRITE;
      busy <= busy_nxt;
      done <= nxt == DONE;
      error <= nxt == ERROR;
      if (load) begin
        len <= length;
        ptr <= '0;
      end
      if (state == RECV_HI && xfer) hi <= byte_in;
      if (state == RECV_LO && xfer) begin
        ram_data <= {hi, byte_in};
        ram_address <= ptr;
      end
      if (state == WRITE && !last) ptr <= ptr + ADDRESS_WIDTH'(1);
    end
  end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sum <= '0;
    else if (load) sum <= '0;
    else if (xfer) sum <= sum + byte_in;
  end
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized loads checked against a transaction-level model of expected RAM writes and flags
module tb_program_loader;
  localparam int AW = 16, DW = 16, BW = 8, DEPTH = 64;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [AW-1:0] length = '0;
  logic [BW-1:0] byte_in = '0;
  logic byte_ready, ram_rw, busy, done, error;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  program_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE(BW), .MEMORY_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .length(length), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_rw(ram_rw), .ram_address(ram_address),
    .ram_data(ram_data), .busy(busy), .done(done), .error(error));
  always #5 clock = ~clock;
  int vectors = 0, miscompares = 0, writes = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [7:0] bytes_q [$];
  logic [31:0] mon_e;
  logic prev_rw = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fill(input int n);
    bytes_q.delete();
    for (int i = 0; i < 2 * n; i++) bytes_q.push_back(8'($urandom));
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (g == 0 && $urandom_range(0, 1) == 1) begin
        start = 1'b1;
        length = '0;
      end
      @(negedge clock);
      start = 1'b0;
    end
    byte_in = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 50 && !byte_ready; k++) @(negedge clock);
    if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 1);
    else @(negedge clock);
  endtask
  task automatic run_load(input int len, input int maxgap, input int lo_gap, input logic [7:0] cs_delta);
    logic [7:0] sum;
    logic exp_err;
    int w0;
    sum = 8'h00;
    w0 = writes;
    exp_err = len > DEPTH;
    if (len > 0 && len <= DEPTH)
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({16'(i), bytes_q[2*i], bytes_q[2*i+1]});
        sum = sum + bytes_q[2*i] + bytes_q[2*i+1];
      end
    @(negedge clock);
    start = 1'b1;
    length = AW'(len);
    @(negedge clock);
    start = 1'b0;
    length = AW'($urandom);
    if (len > 0 && len <= DEPTH) begin
      for (int i = 0; i < 2 * len; i++)
        send_byte(bytes_q[i], (i == 1 && lo_gap >= 0) ? lo_gap : $urandom_range(0, maxgap));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'(8'h00 - sum) + cs_delta, $urandom_range(0, maxgap));
      exp_err = cs_delta != 8'h00;
`endif
      byte_valid = 1'b0;
    end
    for (int k = 0; k < 20 && !(done || error); k++) @(negedge clock);
    check("done", 32'(done), 32'(!exp_err));
    check("error", 32'(error), 32'(exp_err));
    check("busy_after", 32'(busy), 0);
    check("write_count", writes - w0, (len > 0 && len <= DEPTH) ? len : 0);
    check("writes_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    logic [15:0] last_word, first_word;
    fork
      forever begin
        @(negedge clock);
        if (!reset) begin
          check("done_error_exclusive", 32'(done && error), 0);
          check("ready_implies_busy", 32'(byte_ready && !busy), 0);
          check("rw_single_cycle", 32'(ram_rw && prev_rw), 0);
          if (ram_rw) begin
            writes++;
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
              mon_e = exp_q.pop_front();
              check("ram_address", 32'(ram_address), 32'(mon_e[31:16]));
              check("ram_data", 32'(ram_data), 32'(mon_e[15:0]));
            end
            mem[ram_address[5:0]] = ram_data;
          end
        end
        prev_rw = ram_rw;
      end
    join_none
    @(negedge clock);
    check("reset_outputs", {27'b0, byte_ready, ram_rw, busy, done, error}, 0);
    check("reset_addr_data", {ram_address, ram_data}, 0);
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1;
    length = 16'd2;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'h01, 0);
    byte_valid = 1'b0;
    check("mid_load_ready", 32'(byte_ready), 1);
    #1 reset = 1'b1;
    #1 check("async_reset_outputs", {28'b0, byte_ready, ram_rw, busy, done}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {29'b0, byte_ready, busy, done}, 0);
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(2, 0, -1, 8'h00);
    check("mem0_basic", 32'(mem[0]), 32'h0102);
    check("mem1_basic", 32'(mem[1]), 32'h0304);
    bytes_q = '{8'h01, 8'h02};
    run_load(1, 0, 5, 8'h00);
    check("mem0_backpressure", 32'(mem[0]), 32'h0102);
    run_load(65, 0, -1, 8'h00);
    run_load(0, 0, -1, 8'h00);
    check("len0_done_literal", {30'b0, done, error}, 2);
    fill(64);
    last_word = {bytes_q[126], bytes_q[127]};
    first_word = {bytes_q[0], bytes_q[1]};
    run_load(64, 1, -1, 8'h00);
    check("mem63_full", 32'(mem[63]), 32'(last_word));
    check("mem0_no_wrap", 32'(mem[0]), 32'(first_word));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    bytes_q = '{8'h01, 8'h02};
    run_load(1, 0, -1, 8'h00);
    bytes_q = '{8'h01, 8'h02};
    run_load(1, 0, -1, 8'h01);
    check("cs_bad_word_written", 32'(mem[0]), 32'h0102);
`endif
    for (int t = 0; t < 30; t++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(65, 300)) : $urandom_range(1, 10);
      fill(len);
      run_load(len, 3, -1, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    end
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
